// File: rtl/or_gate_8_pkg.sv
// or_gate_8_pkg: shared widths and types for the 8-input OR gate
// and its input-vector coverage tracker.
package or_gate_8_pkg;

    localparam int NUM_IN  = 8;
    localparam int NUM_VEC = 256;
    localparam int COUNT_W = 9;

    // Vector index: i1 is the MSB, i8 the LSB.
    typedef logic [NUM_IN-1:0] vec_t;

    typedef logic [COUNT_W-1:0] count_t;

    // Count value meaning every vector has been seen.
    localparam count_t FULL_COUNT = count_t'(NUM_VEC);

    // Pack the eight operands into a vector index, i1 most significant.
    function automatic vec_t pack_vec(
        input logic a1,
        input logic a2,
        input logic a3,
        input logic a4,
        input logic a5,
        input logic a6,
        input logic a7,
        input logic a8
    );
        return {a1, a2, a3, a4, a5, a6, a7, a8};
    endfunction

    function automatic logic is_full(input count_t cnt);
        return cnt == FULL_COUNT;
    endfunction

endpackage

// File: rtl/or_gate_8_cov.sv
// or_gate_8_cov: records which of the 256 input vectors have been seen.
// Ports: clk, rst (sync, active-high), v (vector index) -> cov_count, cov_done.
module or_gate_8_cov
    import or_gate_8_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  vec_t   v,
    output count_t cov_count,
    output logic   cov_done
);

    logic [NUM_VEC-1:0] r_seen;
    count_t             r_count;
    logic               w_first;

    // A vector counts only the first time it is observed after reset.
    assign w_first = ~r_seen[v];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen  <= '0;
            r_count <= '0;
        end else if (w_first) begin
            r_seen[v] <= 1'b1;
            r_count   <= r_count + count_t'(1);
        end
    end

    // The counter cannot pass 256: once all bits are set no first hit exists.
    assign cov_count = r_count;
    assign cov_done  = is_full(r_count);

endmodule

// File: rtl/or_gate_8.sv
// or_gate_8: 8-input OR with a registered output copy and coverage tracking.
// Ports: i1..i8 operands, c comb OR, c_q registered c, cov_count/cov_done coverage.
module or_gate_8
    import or_gate_8_pkg::*;
(
    output logic   c,
    input  logic   i1,
    input  logic   i2,
    input  logic   i3,
    input  logic   i4,
    input  logic   i5,
    input  logic   i6,
    input  logic   i7,
    input  logic   i8,
    input  logic   clk,
    input  logic   rst,
    output logic   c_q,
    output count_t cov_count,
    output logic   cov_done
);

    vec_t w_v;
    logic w_c;
    logic r_c_q;

    assign w_v = pack_vec(i1, i2, i3, i4, i5, i6, i7, i8);
    assign w_c = |w_v;
    assign c   = w_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_q <= 1'b0;
        end else begin
            r_c_q <= w_c;
        end
    end

    assign c_q = r_c_q;

    or_gate_8_cov u_cov (
        .clk       (clk),
        .rst       (rst),
        .v         (w_v),
        .cov_count (cov_count),
        .cov_done  (cov_done)
    );

endmodule

// File: tb/tb_or_gate_8.sv
// tb_or_gate_8: randomized and directed checks of or_gate_8 against
// a set-based reference model of OR and vector coverage.
module tb_or_gate_8;

    logic       clk;
    logic       rst;
    logic       c;
    logic       i1, i2, i3, i4, i5, i6, i7, i8;
    logic       c_q;
    logic [8:0] cov_count;
    logic       cov_done;

    int n_checks;
    int n_errors;

    bit m_seen [256];
    int m_cq;
    int m_count;

    or_gate_8 dut (
        .c         (c),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .i4        (i4),
        .i5        (i5),
        .i6        (i6),
        .i7        (i7),
        .i8        (i8),
        .clk       (clk),
        .rst       (rst),
        .c_q       (c_q),
        .cov_count (cov_count),
        .cov_done  (cov_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_v();
        logic [7:0] t;
        t = {i1, i2, i3, i4, i5, i6, i7, i8};
        return int'(t);
    endfunction

    // Apply a vector and check the combinational output at once.
    task automatic set_v(input int v);
        logic [7:0] t;
        t = v[7:0];
        {i1, i2, i3, i4, i5, i6, i7, i8} = t;
        #1;
        chk("c", int'(c), (v != 0) ? 1 : 0);
    endtask

    // One clock edge: update the reference model, then check registered outputs.
    task automatic clk_edge();
        int v;
        @(posedge clk);
        v = cur_v();
        if (rst) begin
            foreach (m_seen[k]) m_seen[k] = 1'b0;
            m_cq = 0;
        end else begin
            m_seen[v] = 1'b1;
            m_cq = (v != 0) ? 1 : 0;
        end
        m_count = 0;
        foreach (m_seen[k]) m_count += int'(m_seen[k]);
        #1;
        chk("c_q", int'(c_q), m_cq);
        chk("cov_count", int'(cov_count), m_count);
        chk("cov_done", int'(cov_done), (m_count == 256) ? 1 : 0);
    endtask

    initial begin
        int start_count;
        n_checks = 0;
        n_errors = 0;
        m_cq = 0;
        m_count = 0;
        rst = 1'b1;
        {i1, i2, i3, i4, i5, i6, i7, i8} = 8'h00;
        #2;
        clk_edge();
        clk_edge();
        chk("reset_count", int'(cov_count), 0);
        rst = 1'b0;

        // All zero vector
        set_v(8'h00);
        clk_edge();

        // v = 0x15
        set_v(8'h15);
        chk("c_0x15", int'(c), 1);
        clk_edge();
        chk("c_q_0x15", int'(c_q), 1);

        // v = 0x59 held for three edges: counted once
        set_v(8'h59);
        start_count = int'(cov_count);
        clk_edge();
        clk_edge();
        clk_edge();
        chk("hold_once", int'(cov_count), start_count + 1);

        // Fresh exhaustive sweep
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        for (int v = 0; v < 256; v++) begin
            set_v(v);
            clk_edge();
        end
        chk("sweep_count", int'(cov_count), 256);
        chk("sweep_done", int'(cov_done), 1);

        // Reset after 100 vectors; c keeps following inputs during reset
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        for (int v = 0; v < 100; v++) begin
            set_v(v);
            clk_edge();
        end
        rst = 1'b1;
        set_v(8'hA5);
        clk_edge();
        chk("mid_rst_count", int'(cov_count), 0);
        chk("mid_rst_cq", int'(c_q), 0);
        set_v(8'h00);
        set_v(8'h01);
        rst = 1'b0;
        for (int v = 0; v < 255; v++) begin
            set_v(v);
            clk_edge();
        end
        chk("almost_done", int'(cov_done), 0);
        set_v(255);
        clk_edge();
        chk("resweep_done", int'(cov_done), 1);

        // Glitch between edges: only the value at the edge is recorded
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        set_v(8'h00);
        set_v(8'h80);
        set_v(8'h00);
        clk_edge();
        chk("glitch_count", int'(cov_count), 1);
        set_v(8'h80);
        clk_edge();
        chk("glitch_next", int'(cov_count), 2);

        // Random vectors with occasional reset
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 29) == 0);
            set_v(int'($urandom_range(0, 255)));
            clk_edge();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
